note_sequencer: RTL and testbench
=================================

# note_sequencer

Parametrised multi-lane note pattern sequencer for the rhythm-game datapath. It steps through a selectable pattern ROM at a tick-driven tempo and drives NUM_CH lane-position outputs, each phase-shifted by a fixed note offset. It supports one-shot or looping playback, start, stop and pause control, and strobes for note start, wrap and done. It feeds the note renderer and hit-judge logic.

## Interface
- NUM_CH, 2: number of lane-position output channels (1..8).
- NUM_NOTES, 10: notes per pattern (2..64).
- STEP_LEN, 8: ticks per note when the tempo port is absent (1..255).
- CH_OFFSET, 1: note-index offset between adjacent channels; must be less than NUM_NOTES.
- POS_W, 4: lane-code width.
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low.
- tick  in  1  tempo enable; advances the sub-note counter by one.
- start  in  1  single-cycle start pulse.
- stop  in  1  single-cycle stop pulse.
- pause  in  1  level; while high, tick is ignored.
- loop_mode  in  1  1 = loop forever, 0 = one-shot.
- pattern_sel  in  1  pattern select, latched on start.
- pos  out  NUM_CH*POS_W  lane code per channel; channel c occupies bits [c*POS_W +: POS_W].
- note_start  out  1  high for the first cycle of each note.
- wrap  out  1  one-cycle pulse when looping back to note 0.
- done  out  1  one-cycle pulse when a one-shot pattern ends.
- busy  out  1  high in RUN or PAUSE.
- note_idx  out  IDX_W  current base note index. IDX_W = $clog2(NUM_NOTES).

## Operation
- Lane codes are shared constants: NONE=0, Q=1, W=2, E=3, A=4, S=5, D=6, Z=7, X=8, C=9.
- Pattern 0 (row-major): Q W E A S D Z X C NONE.
- Pattern 1 (column-major): Q A Z W S X E D C NONE.
- For NUM_NOTES other than 10, the ROM repeats these entries modulo 10.
- FSM states: IDLE, RUN, PAUSE.
- IDLE to RUN on start. Start latches pattern_sel and clears note_idx and sub_cnt.
- RUN to PAUSE while pause is high; PAUSE to RUN when pause is low.
- Any state goes to IDLE on stop.
- start in RUN or PAUSE restarts playback from note 0.
- stop has priority over start and over end-of-pattern.
- In RUN, each tick increments sub_cnt. When sub_cnt reaches len-1 on a tick, sub_cnt returns to 0 and note_idx advances.
- At the end of the last note:
  - loop_mode=1: note_idx goes to 0 and wrap pulses.
  - loop_mode=0: the FSM goes to IDLE and done pulses.
- loop_mode is sampled at the end-of-pattern moment, not at start.
- Channel c plays ROM[pat][(note_idx + c*CH_OFFSET) mod NUM_NOTES]. The modulo is computed without a divider, using a compare-subtract on an IDX_W+3 bit sum.
- In IDLE, every pos lane is NONE.
- stop coinciding with end-of-pattern produces no done and no wrap.

## Timing
- Reset values: state=IDLE, note_idx=0, sub_cnt=0, latched pattern=0, pos=0, note_start=0, wrap=0, done=0, busy=0.
- All state is registered. pos is combinational from the registered state, note_idx and latched pattern.
- start at edge N: busy=1, note_idx=0 and note_start=1 in cycle N+1.
- Note advance at edge N: the new pos appears, and note_start=1, in cycle N+1.
- done and wrap are registered and high for exactly the one cycle after the terminating tick edge.
- A held pause freezes sub_cnt and note_idx with no loss. The first tick after pause falls continues the count where it stopped.
- A reset assertion mid-run returns all outputs to their reset values immediately (asynchronous).

## Configuration
- Macro NOTE_SEQ_TEMPO_EN.
- Defined: adds port `tempo  in  8`, the ticks per note.
  - tempo is latched on start and used as len.
  - tempo=0 is treated as 1.
  - STEP_LEN is ignored.
- Undefined: there is no tempo port and len=STEP_LEN.

## Structure
- Package note_seq_pkg holds:
  - the lane-code localparams NONE..C;
  - the state enum;
  - the pattern constant arrays.
- Sub-module note_rom: combinational lookup with inputs pattern select and note index, output a POS_W lane code. It is instantiated once per channel in a generate loop.
- The top level holds the FSM, the sub_cnt and note_idx counters, and the strobe registers.

## Test plan
All scenarios use NUM_CH=2, NUM_NOTES=10, STEP_LEN=8, CH_OFFSET=1 and tick every cycle unless stated otherwise.
- Reset low mid-run -> pos=0, busy=0, note_idx=0 immediately; outputs stay there after release until start.
- start with pattern_sel=0, loop_mode=0:
  - ch0 plays 1,2,3,4,5,6,7,8,9,0 for 8 cycles each;
  - ch1 plays 2,3,...,9,0,1;
  - done pulses once after 80 ticks, then busy=0.
- pattern_sel=1, loop_mode=1:
  - ch0 plays 1,4,7,2,5,8,3,6,9,0;
  - after 80 ticks, wrap pulses, note_idx=0 and busy stays 1.
- pause held 5 cycles at sub_cnt=3 of note 2 -> pos and note_idx are frozen; note 3 begins exactly 5 ticks after pause falls.
- stop asserted on the final tick of a one-shot run -> IDLE, done=0. Then start together with stop in IDLE -> stays IDLE.
- With NOTE_SEQ_TEMPO_EN: tempo=3 -> each note lasts 3 ticks and done pulses after 30 ticks; tempo=0 -> each note lasts 1 tick.

Source files
------------

// File: rtl/note_seq_pkg.sv
// note_seq_pkg: lane codes, sequencer states and the two 3x3-grid pattern tables.
package note_seq_pkg;
   localparam logic [3:0] NONE = 4'd0, Q = 4'd1, W = 4'd2, E = 4'd3, A = 4'd4,
                          S = 4'd5, D = 4'd6, Z = 4'd7, X = 4'd8, C = 4'd9;
   typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
   localparam logic [3:0] PAT_ROW [10] = '{Q, W, E, A, S, D, Z, X, C, NONE};
   localparam logic [3:0] PAT_COL [10] = '{Q, A, Z, W, S, X, E, D, C, NONE};
endpackage

// File: rtl/note_sequencer_rom.sv
// note_rom: combinational pattern lookup; longer patterns repeat the 10-entry tables.
module note_rom #(
   parameter int IDX_W = 4,
   parameter int POS_W = 4
) (
   input  logic             pat,
   input  logic [IDX_W-1:0] idx,
   output logic [POS_W-1:0] code
);
   import note_seq_pkg::*;
   logic [3:0] i;
   logic [3:0] ent;
   always_comb begin
      i = 4'(int'(idx) % 10);
      ent = pat ? PAT_COL[i] : PAT_ROW[i];
      code = POS_W'(ent);
   end
endmodule

// File: rtl/note_sequencer.sv
// note_sequencer: tick-paced multi-lane note pattern player with loop/one-shot playback.
// Define NOTE_SEQ_TEMPO_EN to add an 8-bit tempo port (ticks per note, latched on start).
module note_sequencer #(
   parameter  int NUM_CH    = 2,
   parameter  int NUM_NOTES = 10,
   parameter  int STEP_LEN  = 8,
   parameter  int CH_OFFSET = 1,
   parameter  int POS_W     = 4,
   localparam int IDX_W     = $clog2(NUM_NOTES)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    tick,
   input  logic                    start,
   input  logic                    stop,
   input  logic                    pause,
   input  logic                    loop_mode,
   input  logic                    pattern_sel,
`ifdef NOTE_SEQ_TEMPO_EN
   input  logic [7:0]              tempo,
`endif
   output logic [NUM_CH*POS_W-1:0] pos,
   output logic                    note_start,
   output logic                    wrap,
   output logic                    done,
   output logic                    busy,
   output logic [IDX_W-1:0]        note_idx
);
   import note_seq_pkg::*;
   state_t state, state_nx;
   logic [7:0] sub_cnt, len;
   logic pat, cnt_en, adv, last, fin;
`ifdef NOTE_SEQ_TEMPO_EN
   logic [7:0] len_r;
   always_ff @(posedge clk or negedge rst)
      if (!rst) len_r <= 8'd1;
      else if (start && !stop) len_r <= (tempo == 8'd0) ? 8'd1 : tempo;
   assign len = len_r;
`else
   assign len = 8'(STEP_LEN);
`endif
   assign busy   = state != IDLE;
   assign cnt_en = busy && !pause && tick;
   assign adv    = cnt_en && sub_cnt == len - 8'd1;
   assign last   = adv && note_idx == IDX_W'(NUM_NOTES - 1);
   assign fin    = last && !loop_mode;
   always_comb begin
      state_nx = state;
      if (stop) state_nx = IDLE;
      else if (start) state_nx = RUN;
      else if (busy) state_nx = fin ? IDLE : pause ? PAUSE : RUN;
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         note_idx   <= '0;
         sub_cnt    <= '0;
         pat        <= 1'b0;
         note_start <= 1'b0;
         wrap       <= 1'b0;
         done       <= 1'b0;
      end else begin
         state      <= state_nx;
         note_start <= !stop && (start || (adv && !fin));
         wrap       <= !stop && !start && last && loop_mode;
         done       <= !stop && !start && fin;
         if (stop || start) begin
            note_idx <= '0;
            sub_cnt  <= '0;
         end else if (adv) begin
            sub_cnt  <= '0;
            note_idx <= last ? '0 : note_idx + 1'b1;
         end else if (cnt_en) sub_cnt <= sub_cnt + 8'd1;
         if (start && !stop) pat <= pattern_sel;
      end
   end
   // Offsets are pre-reduced mod NUM_NOTES so one compare-subtract suffices.
   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      localparam int OFF = (c * CH_OFFSET) % NUM_NOTES;
      logic [IDX_W+2:0] sum;
      logic [IDX_W-1:0] idx;
      logic [POS_W-1:0] code;
      assign sum = (IDX_W+3)'(note_idx) + (IDX_W+3)'(OFF);
      assign idx = IDX_W'((sum >= (IDX_W+3)'(NUM_NOTES)) ? sum - (IDX_W+3)'(NUM_NOTES) : sum);
      note_rom #(.IDX_W(IDX_W), .POS_W(POS_W)) u_rom (.pat(pat), .idx(idx), .code(code));
      assign pos[c*POS_W +: POS_W] = busy ? code : '0;
   end
endmodule

// File: tb/tb_note_sequencer.sv
// tb_note_sequencer: vector table, corner-case sequences and random play against a reference model.
module tb_note_sequencer;
   localparam int NC = 2, NN = 10, SL = 8, OFF = 1, PW = 4, IW = $clog2(NN);
   logic clk = 0, rst = 0, tick = 0, start = 0, stop = 0, pause = 0, loop_mode = 0, pattern_sel = 0;
   logic [NC*PW-1:0] pos;
   logic note_start, wrap, done, busy;
   logic [IW-1:0] note_idx;
`ifdef NOTE_SEQ_TEMPO_EN
   logic [7:0] tempo = 8'd8;
`endif
   int checks = 0, errors = 0;
   int m_busy, m_idx, m_cnt, m_pat, m_len, m_ns, m_wrap, m_done;

   always #5 clk = ~clk;

   note_sequencer #(.NUM_CH(NC), .NUM_NOTES(NN), .STEP_LEN(SL), .CH_OFFSET(OFF), .POS_W(PW)) dut (
      .clk(clk), .rst(rst), .tick(tick), .start(start), .stop(stop), .pause(pause),
      .loop_mode(loop_mode), .pattern_sel(pattern_sel),
`ifdef NOTE_SEQ_TEMPO_EN
      .tempo(tempo),
`endif
      .pos(pos), .note_start(note_start), .wrap(wrap), .done(done), .busy(busy), .note_idx(note_idx));

   // Keypad grid 1..9 then NONE; pattern 1 walks the 3x3 grid by columns.
   function automatic int lane(int p, int n);
      int i = n % 10;
      if (i == 9) return 0;
      return p ? (i % 3) * 3 + i / 3 + 1 : i + 1;
   endfunction

   function automatic logic [NC*PW-1:0] exp_pos();
      logic [NC*PW-1:0] r = '0;
      if (m_busy != 0)
         for (int c = 0; c < NC; c++) r[c*PW +: PW] = PW'(lane(m_pat, (m_idx + c*OFF) % NN));
      return r;
   endfunction

   task automatic chk(string nm, longint act, longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
      end
   endtask

   task automatic m_reset();
      m_busy = 0; m_idx = 0; m_cnt = 0; m_pat = 0; m_ns = 0; m_wrap = 0; m_done = 0;
`ifdef NOTE_SEQ_TEMPO_EN
      m_len = 1;
`else
      m_len = SL;
`endif
   endtask

   task automatic m_step();
      m_ns = 0; m_wrap = 0; m_done = 0;
      if (stop) begin
         m_busy = 0; m_idx = 0; m_cnt = 0;
      end else if (start) begin
         m_busy = 1; m_pat = pattern_sel; m_idx = 0; m_cnt = 0; m_ns = 1;
`ifdef NOTE_SEQ_TEMPO_EN
         m_len = (tempo == 0) ? 1 : tempo;
`endif
      end else if (m_busy != 0 && !pause && tick) begin
         m_cnt++;
         if (m_cnt == m_len) begin
            m_cnt = 0; m_idx++; m_ns = 1;
            if (m_idx == NN) begin
               m_idx = 0;
               if (loop_mode) m_wrap = 1;
               else begin m_busy = 0; m_done = 1; m_ns = 0; end
            end
         end
      end
   endtask

   task automatic compare();
      chk("busy", busy, m_busy);
      chk("note_idx", note_idx, m_idx);
      chk("note_start", note_start, m_ns);
      chk("wrap", wrap, m_wrap);
      chk("done", done, m_done);
      chk("pos", pos, exp_pos());
   endtask

   task automatic cyc(int n = 1);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         if (rst) m_step(); else m_reset();
         #1;
         compare();
      end
   endtask

   typedef struct {
      logic st, sp, pa, tk, sel, lp;
      int n;
      logic eb; int ei; logic [7:0] ep; logic ens, ed, ew;
   } vec_t;
   vec_t tbl[14];

   initial begin
      tbl[0]  = '{1,0,0,1,0,0,  1, 1,0,8'h21,1,0,0};
      tbl[1]  = '{0,0,0,1,0,0,  7, 1,0,8'h21,0,0,0};
      tbl[2]  = '{0,0,0,1,0,0,  1, 1,1,8'h32,1,0,0};
      tbl[3]  = '{0,0,0,1,0,0, 64, 1,9,8'h10,1,0,0};
      tbl[4]  = '{0,0,0,1,0,0,  7, 1,9,8'h10,0,0,0};
      tbl[5]  = '{0,0,0,1,0,0,  1, 0,0,8'h00,0,1,0};
      tbl[6]  = '{0,0,0,1,0,0,  1, 0,0,8'h00,0,0,0};
      tbl[7]  = '{1,0,0,1,1,1,  1, 1,0,8'h41,1,0,0};
      tbl[8]  = '{0,0,0,1,1,1,  8, 1,1,8'h74,1,0,0};
      tbl[9]  = '{0,0,1,1,1,1,  5, 1,1,8'h74,0,0,0};
      tbl[10] = '{0,0,0,1,1,1, 72, 1,0,8'h41,1,0,1};
      tbl[11] = '{0,0,0,1,1,1,  1, 1,0,8'h41,0,0,0};
      tbl[12] = '{0,1,0,1,1,1,  1, 0,0,8'h00,0,0,0};
      tbl[13] = '{1,1,0,1,1,1,  1, 0,0,8'h00,0,0,0};
      m_reset();
      cyc(2);
      rst = 1;
      cyc(1);
      foreach (tbl[i]) begin
         start = tbl[i].st; stop = tbl[i].sp; pause = tbl[i].pa; tick = tbl[i].tk;
         pattern_sel = tbl[i].sel; loop_mode = tbl[i].lp;
         cyc(tbl[i].n);
         chk($sformatf("vec%0d busy", i), busy, tbl[i].eb);
         chk($sformatf("vec%0d note_idx", i), note_idx, tbl[i].ei);
         chk($sformatf("vec%0d pos", i), pos, tbl[i].ep);
         chk($sformatf("vec%0d note_start", i), note_start, tbl[i].ens);
         chk($sformatf("vec%0d done", i), done, tbl[i].ed);
         chk($sformatf("vec%0d wrap", i), wrap, tbl[i].ew);
      end
      start = 0; stop = 0; pause = 0;

      // asynchronous reset in the middle of a run
      start = 1; pattern_sel = 0; loop_mode = 1; cyc(1); start = 0; cyc(20);
      rst = 0; #1;
      chk("async_rst busy", busy, 0);
      chk("async_rst pos", pos, 0);
      chk("async_rst note_idx", note_idx, 0);
      m_reset();
      cyc(2); rst = 1; cyc(4);
      chk("post_rst busy", busy, 0);

      // pause held at sub_cnt 3 of note 2
      start = 1; loop_mode = 0; cyc(1); start = 0; cyc(19);
      pause = 1; cyc(5);
      chk("pause idx", note_idx, 2);
      chk("pause pos", pos, 8'h43);
      pause = 0; cyc(4);
      chk("resume idx", note_idx, 2);
      cyc(1);
      chk("resume adv idx", note_idx, 3);
      chk("resume note_start", note_start, 1);
      stop = 1; cyc(1); stop = 0;

      // stop on the final tick of a one-shot run
      start = 1; cyc(1); start = 0; cyc(79);
      chk("pre_stop busy", busy, 1);
      stop = 1; cyc(1);
      chk("stop_end busy", busy, 0);
      chk("stop_end done", done, 0);
      stop = 0; cyc(1);
      chk("stop_end done2", done, 0);
      start = 1; stop = 1; cyc(1);
      chk("start_stop busy", busy, 0);
      start = 0; stop = 0;

`ifdef NOTE_SEQ_TEMPO_EN
      tempo = 3; start = 1; cyc(1); start = 0; cyc(29);
      chk("tempo3 idx", note_idx, 9);
      chk("tempo3 busy", busy, 1);
      cyc(1);
      chk("tempo3 done", done, 1);
      tempo = 0; start = 1; cyc(1); start = 0; cyc(1);
      chk("tempo0 idx", note_idx, 1);
      stop = 1; cyc(1); stop = 0; tempo = 8;
`endif

      for (int k = 0; k < 3000; k++) begin
         start = $urandom_range(0, 39) == 0;
         stop = $urandom_range(0, 149) == 0;
         if ($urandom_range(0, 15) == 0) pause = ~pause;
         tick = $urandom_range(0, 3) != 0;
         if ($urandom_range(0, 63) == 0) loop_mode = ~loop_mode;
         pattern_sel = 1'($urandom);
`ifdef NOTE_SEQ_TEMPO_EN
         tempo = 8'($urandom_range(0, 4));
`endif
         cyc(1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
